// File: rtl/fm_422_ctrl.sv
// Pair-phase sequencer, sync/DE delay and Cb/Cr interleaver for the 4:4:4->4:2:2 decimator.
// Latency is 3 cycles (2 in the delay line plus 1 output register). There is no backpressure: video timing is free-running.
module fm_422_ctrl (
   input  logic        clk_v,
   input  logic        rst_x,
   input  logic        i_de,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic        i_err_clr,
   output logic        o_state,
   input  logic [7:0]  i_dec_y,
   input  logic [7:0]  i_dec_cb,
   input  logic [7:0]  i_dec_cr,
   output logic        o_de,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic [7:0]  o_y,
   output logic [7:0]  o_c,
   output logic        o_c_sel,
   output logic [11:0] o_line_len,
   output logic        o_err_odd
);

   // EVEN means an odd number of pixels has been seen so far, so a pair is still open.
   typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

   state_t      state, state_nxt;
   logic        r_phase;
   logic        line_end;
   logic        odd_end;
   logic [11:0] pix_cnt;
   logic [2:0]  sync_1z, sync_2z;
   logic        r_phase_1z, r_phase_2z;

   assign o_state = i_de & r_phase;

   always_comb begin
      state_nxt = state;
      line_end  = 1'b0;
      odd_end   = 1'b0;
      case (state)
         IDLE: if (i_de) state_nxt = EVEN;
         EVEN: begin
            if (i_de) begin
               state_nxt = ODD;
            end else begin
               state_nxt = IDLE;
               line_end  = 1'b1;
               odd_end   = 1'b1;
            end
         end
         ODD: begin
            if (i_de) begin
               state_nxt = EVEN;
            end else begin
               state_nxt = IDLE;
               line_end  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_v) begin
      if (!rst_x) begin
         state      <= IDLE;
         r_phase    <= 1'b0;
         pix_cnt    <= 12'd0;
         o_line_len <= 12'd0;
         o_err_odd  <= 1'b0;
      end else begin
         state   <= state_nxt;
         r_phase <= i_de ? ~r_phase : 1'b0;
         if (line_end) begin
            o_line_len <= pix_cnt;
            pix_cnt    <= 12'd0;
         end else if (i_de) begin
            pix_cnt <= pix_cnt + 12'd1;
         end
         // An odd line end takes priority over a coincident clear.
         if (odd_end)
            o_err_odd <= 1'b1;
         else if (i_err_clr)
            o_err_odd <= 1'b0;
      end
   end

   always_ff @(posedge clk_v) begin
      if (!rst_x) begin
         sync_1z    <= 3'd0;
         sync_2z    <= 3'd0;
         r_phase_1z <= 1'b0;
         r_phase_2z <= 1'b0;
         o_de       <= 1'b0;
         o_hsync    <= 1'b0;
         o_vsync    <= 1'b0;
         o_y        <= 8'h10;
         o_c        <= 8'h80;
         o_c_sel    <= 1'b0;
      end else begin
         sync_1z    <= {i_vsync, i_hsync, i_de};
         sync_2z    <= sync_1z;
         r_phase_1z <= r_phase;
         r_phase_2z <= r_phase_1z;
         o_de       <= sync_2z[0];
         o_hsync    <= sync_2z[1];
         o_vsync    <= sync_2z[2];
         if (sync_2z[0]) begin
            o_y     <= i_dec_y;
            o_c     <= r_phase_2z ? i_dec_cr : i_dec_cb;
            o_c_sel <= r_phase_2z;
         end else begin
            o_y     <= 8'h10;
            o_c     <= 8'h80;
            o_c_sel <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fm_422_ctrl.sv
// Bench for fm_422_ctrl: a behavioural decimator feeds i_dec_*, and a queue holds each cycle's expected output 3 cycles ahead.
module tb_fm_422_ctrl;

   logic        clk_v = 1'b0;
   logic        rst_x, i_de, i_hsync, i_vsync, i_err_clr;
   logic        o_state;
   logic [7:0]  i_dec_y, i_dec_cb, i_dec_cr;
   logic        o_de, o_hsync, o_vsync, o_c_sel, o_err_odd;
   logic [7:0]  o_y, o_c;
   logic [11:0] o_line_len;

   always #5 clk_v = ~clk_v;

   fm_422_ctrl dut (
      .clk_v(clk_v), .rst_x(rst_x), .i_de(i_de), .i_hsync(i_hsync), .i_vsync(i_vsync),
      .i_err_clr(i_err_clr), .o_state(o_state), .i_dec_y(i_dec_y), .i_dec_cb(i_dec_cb),
      .i_dec_cr(i_dec_cr), .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_y(o_y),
      .o_c(o_c), .o_c_sel(o_c_sel), .o_line_len(o_line_len), .o_err_odd(o_err_odd)
   );

   function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8:1];
   endfunction

   // Decimator model: 2-cycle luma delay; Cb/Cr pair average latched on the strobe.
   logic [7:0] pix_y = 8'd0, pix_cb = 8'd0, pix_cr = 8'd0;
   logic [7:0] y_1z = 8'd0, y_2z = 8'd0, prev_cb = 8'd0, prev_cr = 8'd0;
   logic [7:0] avg_cb = 8'd0, avg_cr = 8'd0;

   always @(posedge clk_v) begin
      y_1z    <= pix_y;
      y_2z    <= y_1z;
      prev_cb <= pix_cb;
      prev_cr <= pix_cr;
      if (o_state) begin
         avg_cb <= avg8(prev_cb, pix_cb);
         avg_cr <= avg8(prev_cr, pix_cr);
      end
   end

   assign i_dec_y  = y_2z;
   assign i_dec_cb = avg_cb;
   assign i_dec_cr = avg_cr;

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [7:0] y;
      logic [7:0] c;
      logic       csel;
      logic       cchk;
   } exp_t;

   function automatic exp_t idle_e();
      exp_t e;
      e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
      e.y = 8'h10; e.c = 8'h80; e.csel = 1'b0; e.cchk = 1'b1;
      return e;
   endfunction

   exp_t        q[$];
   logic        tb_ph = 1'b0;
   logic [11:0] exp_len = 12'd0;
   logic        exp_err = 1'b0;
   bit          pend = 1'b0;
   logic [7:0]  lcb[16], lcr[16];
   int          n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: drive, queue the expectation, check at the falling edge, return at the next rising edge.
   task automatic step(input logic rst, input logic de, input logic [7:0] y, input logic [7:0] cb,
                       input logic [7:0] cr, input logic clr, input logic [7:0] ec,
                       input logic ecs, input logic ech);
      exp_t e, g;
      logic hs, vs;
      #1;
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      rst_x = rst; i_de = de; i_hsync = hs; i_vsync = vs; i_err_clr = clr;
      pix_y = y; pix_cb = cb; pix_cr = cr;
      e.de = de; e.hs = hs; e.vs = vs;
      e.y    = de ? y : 8'h10;
      e.c    = de ? ec : 8'h80;
      e.csel = de ? ecs : 1'b0;
      e.cchk = de ? ech : 1'b1;
      if (!rst) e = idle_e();
      q.push_back(e);
      @(negedge clk_v);
      check("o_state", 32'(o_state), 32'(de & tb_ph));
      if (q.size() > 3) begin
         g = q.pop_front();
         check("o_de", 32'(o_de), 32'(g.de));
         check("o_hsync", 32'(o_hsync), 32'(g.hs));
         check("o_vsync", 32'(o_vsync), 32'(g.vs));
         check("o_y", 32'(o_y), 32'(g.y));
         check("o_c_sel", 32'(o_c_sel), 32'(g.csel));
         if (g.cchk) check("o_c", 32'(o_c), 32'(g.c));
      end
      if (pend) begin
         check("o_line_len", 32'(o_line_len), 32'(exp_len));
         check("o_err_odd", 32'(o_err_odd), 32'(exp_err));
         pend = 1'b0;
      end
      if (!rst) foreach (q[i]) q[i] = idle_e();
      tb_ph = (rst && de) ? ~tb_ph : 1'b0;
      @(posedge clk_v);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic clr_pulse();
      step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
      exp_err = 1'b0;
      pend = 1'b1;
   endtask

   // Active line of n pixels from lcb/lcr, optional reset on pixel rst_at, then one DE-low cycle.
   task automatic run_line(input int n, input int rst_at, input logic clr_end);
      int cnt;
      for (int i = 0; i < n; i++) begin
         int s, k;
         logic [7:0] ec;
         logic es, eh;
         s = (rst_at >= 0 && i > rst_at) ? rst_at + 1 : 0;
         k = i - s;
         if (k % 2 == 0) begin
            es = 1'b0;
            eh = (i + 1 < n);
            ec = eh ? avg8(lcb[i], lcb[i+1]) : 8'h00;
         end else begin
            es = 1'b1;
            eh = 1'b1;
            ec = avg8(lcr[i-1], lcr[i]);
         end
         step((i == rst_at) ? 1'b0 : 1'b1, 1'b1, 8'($urandom), lcb[i], lcr[i], 1'b0, ec, es, eh);
         if (i == rst_at) begin
            exp_len = 12'd0;
            exp_err = 1'b0;
            pend = 1'b1;
         end
      end
      cnt = n - ((rst_at >= 0) ? rst_at + 1 : 0);
      step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), clr_end, 8'h00, 1'b0, 1'b1);
      exp_len = 12'(cnt);
      if (cnt % 2 == 1) exp_err = 1'b1;
      else if (clr_end) exp_err = 1'b0;
      pend = 1'b1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 16; i++) begin
         lcb[i] = 8'($urandom);
         lcr[i] = 8'($urandom);
      end
   endtask

   initial begin
      rst_x = 1'b0; i_de = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0; i_err_clr = 1'b0;
      @(posedge clk_v);
      repeat (3) q.push_back(idle_e());
      // Reset held with toggling inputs.
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)), 8'h00, 1'b0, 1'b1);
      exp_len = 12'd0; exp_err = 1'b0; pend = 1'b1;
      idle(4);

      lcb[0] = 8'd10; lcb[1] = 8'd30; lcb[2] = 8'd50; lcb[3] = 8'd70;
      lcr[0] = 8'd20; lcr[1] = 8'd40; lcr[2] = 8'd60; lcr[3] = 8'd80;
      run_line(4, -1, 1'b0);
      idle(4);

      fill_random();
      run_line(3, -1, 1'b0);
      idle(4);
      clr_pulse();
      idle(4);

      fill_random();
      run_line(2, -1, 1'b0);
      fill_random();
      run_line(6, -1, 1'b0);
      idle(4);

      fill_random();
      run_line(3, -1, 1'b1);
      idle(4);

      fill_random();
      run_line(8, 3, 1'b0);
      idle(4);

      fill_random();
      run_line(10, -1, 1'b0);
      idle(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
